photon_ipi_histogrammer: RTL and testbench

- Parametrised successor to the fixed 8-channel photon histogrammer on the clkin domain.
- Detects photons on NCH LVDS channels (level or rising-edge mode) and applies a programmable dead-time veto.
- Accumulates saturating per-channel hit counts and an NIPI-bin inter-photon-interval (IPI) histogram, and drives the masked coincidence outputs.
- Adds a sequenced clear FSM, a registered read port, and collision and overflow flags.

---
 rtl/photon_ipi_histogrammer.sv | 227 ++++++++++++++++++++++
 tb/tb_photon_ipi_histogrammer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/photon_ipi_histogrammer.sv
// photon_ipi_histogrammer
//   Photon detector and histogrammer for NCH LVDS channels on the clkin domain.
//   Per-channel saturating hit counters, an NIPI-bin inter-photon-interval
//   histogram, a dead-time veto, masked coincidence outputs, a sequenced
//   clear and a registered read port.
//
// Ports
//   clkin, rst          clock, asynchronous active-high reset
//   lvds_rx             raw channel inputs (synchronous to clkin)
//   mask1, mask2        channel masks for out1 / out2
//   passthrough         bypass: outputs follow lvds_rx, nothing accumulates
//   edge_mode           1 = rising-edge detection, 0 = level detection
//   cycles_to_veto      dead time after an accepted photon
//   clear_req           clear request level (asynchronous origin)
//   rd_en/rd_sel/rd_addr  read strobe, bank select (0 chan, 1 ipi), bin index
//   rd_data, rd_valid   registered read result, one-cycle valid
//   out1, out2          registered OR of masked accepted photons
//   inveto              new photons currently rejected
//   collision           pulse: photon arrived inside the veto window
//   busy                clear sequence in progress
//   overflow            sticky: some bin hit saturation
module photon_ipi_histogrammer #(
  parameter  int NCH  = 8,
  parameter  int NIPI = 64,
  parameter  int CW   = 32,
  parameter  int VW   = 8,
  localparam int CIW  = (NCH  > 1) ? $clog2(NCH)  : 1,
  localparam int IIW  = (NIPI > 1) ? $clog2(NIPI) : 1,
  localparam int AW   = (CIW > IIW) ? CIW : IIW
) (
  input  logic           clkin,
  input  logic           rst,
  input  logic [NCH-1:0] lvds_rx,
  input  logic [NCH-1:0] mask1,
  input  logic [NCH-1:0] mask2,
  input  logic           passthrough,
  input  logic           edge_mode,
  input  logic [VW-1:0]  cycles_to_veto,
  input  logic           clear_req,
  input  logic           rd_en,
  input  logic           rd_sel,
  input  logic [AW-1:0]  rd_addr,
  output logic [CW-1:0]  rd_data,
  output logic           rd_valid,
  output logic           out1,
  output logic           out2,
  output logic           inveto,
  output logic           collision,
  output logic           busy,
  output logic           overflow
);

  localparam logic [CW-1:0]  BIN_MAX  = {CW{1'b1}};
  localparam logic [VW-1:0]  NIPI_V   = VW'(NIPI);
  localparam logic [AW:0]    NCH_A    = (AW+1)'(NCH);
  localparam logic [AW:0]    NIPI_A   = (AW+1)'(NIPI);
  localparam logic [IIW-1:0] LAST_IDX = IIW'(NIPI - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                   r_state, w_state_nxt;
  logic [IIW-1:0]           r_idx;
  logic [2:0]               r_sync;
  logic [NCH-1:0]           r_lvds_last;
  logic [VW-1:0]            r_cnt;
  logic [NCH-1:0][CW-1:0]   r_chan;
  logic [NIPI-1:0][CW-1:0]  r_ipi;
  logic                     r_out1, r_out2, r_coll, r_overflow;
  logic [CW-1:0]            r_rd_data;
  logic                     r_rd_valid;

  logic [NCH-1:0]           w_raw, w_phot, w_chan_inc, w_chan_sat;
  logic [NIPI-1:0]          w_ipi_inc, w_ipi_sat;
  logic                     w_veto, w_any, w_busy, w_sync_rise, w_clr_start, w_acc;
  logic [CW-1:0]            w_rd_val;

  // ---------------------------------------------------------------- detect
  assign w_raw  = edge_mode ? (lvds_rx & ~r_lvds_last) : lvds_rx;
  assign w_veto = (r_cnt < cycles_to_veto);
  // bypass disables the veto and suppresses every accepted photon
  assign w_phot = (passthrough | w_veto) ? '0 : w_raw;
  assign w_any  = |w_phot;

  // ---------------------------------------------------------------- clear
  // r_sync[1:0] is the 2-FF synchroniser; r_sync[2] is the previous
  // synchronised level used for rising-edge detection.
  assign w_sync_rise = r_sync[1] & ~r_sync[2];
  assign w_busy      = (r_state == S_CLEAR);
  assign w_clr_start = (r_state == S_IDLE) & w_sync_rise;
  // clear-start beats a coincident photon; nothing accumulates while clearing
  assign w_acc       = ~passthrough & ~w_busy & ~w_clr_start;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_state <= S_IDLE;
    end else begin
      r_sync  <= {r_sync[1:0], clear_req};
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_sync_rise)        w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_idx == LAST_IDX)  w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst)              r_idx <= '0;
    else if (w_clr_start) r_idx <= '0;
    else if (w_busy)      r_idx <= r_idx + IIW'(1);
  end

  // ---------------------------------------------------------------- interval counter
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_cnt       <= '1;
      r_lvds_last <= '0;
    end else begin
      r_lvds_last <= lvds_rx;
      if (w_clr_start)      r_cnt <= '1;
      else if (!passthrough) begin
        if (w_any)          r_cnt <= '0;
        else if (r_cnt != '1) r_cnt <= r_cnt + VW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- histogram bins
  // r_cnt holds (interval - 1) at the moment a photon is accepted, so it is
  // directly the IPI bin index.
  always_comb begin
    w_chan_inc = '0;
    w_chan_sat = '0;
    w_ipi_inc  = '0;
    w_ipi_sat  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_chan_inc[i] = w_acc & w_phot[i] & (r_chan[i] != BIN_MAX);
      w_chan_sat[i] = w_acc & w_phot[i] & (r_chan[i] == BIN_MAX);
    end
    for (int k = 0; k < NIPI; k++) begin
      w_ipi_inc[k] = w_acc & w_any & (r_cnt < NIPI_V) & (r_cnt == VW'(k)) & (r_ipi[k] != BIN_MAX);
      w_ipi_sat[k] = w_acc & w_any & (r_cnt < NIPI_V) & (r_cnt == VW'(k)) & (r_ipi[k] == BIN_MAX);
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_chan <= '0;
    end else if (w_clr_start) begin
      r_chan <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (w_chan_inc[i]) r_chan[i] <= r_chan[i] + CW'(1);
    end
  end

  // IPI bins are wiped one per cycle while busy
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_ipi <= '0;
    end else begin
      for (int k = 0; k < NIPI; k++) begin
        if (w_busy && (r_idx == IIW'(k))) r_ipi[k] <= '0;
        else if (w_ipi_inc[k])            r_ipi[k] <= r_ipi[k] + CW'(1);
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst)                           r_overflow <= 1'b0;
    else if (w_clr_start)              r_overflow <= 1'b0;
    else if (|w_chan_sat || |w_ipi_sat) r_overflow <= 1'b1;
  end

  // ---------------------------------------------------------------- outputs
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_out1 <= 1'b0;
      r_out2 <= 1'b0;
      r_coll <= 1'b0;
    end else if (passthrough) begin
      // out2 is deliberately unmasked in bypass
      r_out1 <= |(lvds_rx & mask1);
      r_out2 <= |lvds_rx;
      r_coll <= 1'b0;
    end else begin
      r_out1 <= |(w_phot & mask1);
      r_out2 <= |(w_phot & mask2);
      r_coll <= w_veto & (|w_raw);
    end
  end

  // ---------------------------------------------------------------- read port
  always_comb begin
    w_rd_val = '0;
    if (rd_sel) begin
      if ({1'b0, rd_addr} < NIPI_A) w_rd_val = r_ipi[rd_addr[IIW-1:0]];
    end else begin
      if ({1'b0, rd_addr} < NCH_A)  w_rd_val = r_chan[rd_addr[CIW-1:0]];
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_val;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign out1      = r_out1;
  assign out2      = r_out2;
  assign inveto    = ~passthrough & w_veto;
  assign collision = r_coll;
  assign busy      = w_busy;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_photon_ipi_histogrammer.sv
// Directed bench for photon_ipi_histogrammer with a cycle-level reference
// model (interval bookkeeping + plain integer arrays) checked every cycle,
// plus literal expectations on read-back values and pulse counts.
module tb_photon_ipi_histogrammer;
  localparam int NCH  = 8;
  localparam int NIPI = 16;
  localparam int CW   = 4;
  localparam int VW   = 8;
  localparam int AW   = 4;
  localparam int MAXC = 15;
  localparam int MAXS = 255;

  logic           clkin = 1'b0;
  logic           rst;
  logic [NCH-1:0] lvds_rx, mask1, mask2;
  logic           passthrough, edge_mode;
  logic [VW-1:0]  cycles_to_veto;
  logic           clear_req, rd_en, rd_sel;
  logic [AW-1:0]  rd_addr;
  logic [CW-1:0]  rd_data;
  logic           rd_valid, out1, out2, inveto, collision, busy, overflow;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clkin = ~clkin;

  photon_ipi_histogrammer #(.NCH(NCH), .NIPI(NIPI), .CW(CW), .VW(VW)) dut (
    .clkin(clkin), .rst(rst), .lvds_rx(lvds_rx), .mask1(mask1), .mask2(mask2),
    .passthrough(passthrough), .edge_mode(edge_mode), .cycles_to_veto(cycles_to_veto),
    .clear_req(clear_req), .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .out1(out1), .out2(out2), .inveto(inveto),
    .collision(collision), .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  // m_since = accepted-photon age in active cycles minus one (interval-1),
  // saturating; it is the IPI bin an accepted photon lands in.
  int             m_chan [NCH];
  int             m_ipi  [NIPI];
  int             m_since, m_rdd, m_clr_left, m_clr_idx;
  bit             m_o1, m_o2, m_coll, m_rdv, m_ovf;
  logic [NCH-1:0] m_last;
  bit             q1, q2, q3;

  always @(posedge clkin or posedge rst) begin : model
    logic [NCH-1:0] raw, phot;
    bit             veto, start, busy_m;
    int             a;
    if (rst) begin
      for (int i = 0; i < NCH; i++)  m_chan[i] = 0;
      for (int k = 0; k < NIPI; k++) m_ipi[k]  = 0;
      m_since = MAXS; m_rdd = 0; m_clr_left = 0; m_clr_idx = 0;
      m_o1 = 0; m_o2 = 0; m_coll = 0; m_rdv = 0; m_ovf = 0;
      m_last = '0; q1 = 0; q2 = 0; q3 = 0;
    end else begin
      raw    = edge_mode ? (lvds_rx & ~m_last) : lvds_rx;
      busy_m = (m_clr_left > 0);
      start  = q2 && !q3 && !busy_m;
      veto   = !passthrough && (m_since < int'(cycles_to_veto));
      phot   = (passthrough || veto) ? '0 : raw;
      a      = int'(rd_addr);
      m_rdv  = rd_en;
      if (rd_en) m_rdd = rd_sel ? ((a < NIPI) ? m_ipi[a] : 0) : ((a < NCH) ? m_chan[a] : 0);
      if (passthrough) begin
        m_o1 = |(lvds_rx & mask1); m_o2 = |lvds_rx; m_coll = 0;
      end else begin
        m_o1 = |(phot & mask1); m_o2 = |(phot & mask2); m_coll = veto && (raw != 0);
      end
      if (start) begin
        for (int i = 0; i < NCH; i++) m_chan[i] = 0;
        m_ovf = 0; m_since = MAXS; m_clr_left = NIPI; m_clr_idx = 0;
      end else begin
        if (busy_m) begin
          m_ipi[m_clr_idx] = 0; m_clr_idx++; m_clr_left--;
        end
        if (!passthrough) begin
          if (!busy_m) begin
            for (int i = 0; i < NCH; i++)
              if (phot[i]) begin
                if (m_chan[i] == MAXC) m_ovf = 1; else m_chan[i]++;
              end
            if (phot != 0 && m_since < NIPI) begin
              if (m_ipi[m_since] == MAXC) m_ovf = 1; else m_ipi[m_since]++;
            end
          end
          m_since = (phot != 0) ? 0 : ((m_since < MAXS) ? m_since + 1 : MAXS);
        end
      end
      m_last = lvds_rx; q3 = q2; q2 = q1; q1 = clear_req;
    end
  end

  // ------------------------------------------------------------ per-cycle compare
  always @(negedge clkin) begin
    if (!rst && cmp_en) begin
      chk("out1",      int'(out1),      int'(m_o1));
      chk("out2",      int'(out2),      int'(m_o2));
      chk("collision", int'(collision), int'(m_coll));
      chk("busy",      int'(busy),      int'(m_clr_left > 0));
      chk("overflow",  int'(overflow),  int'(m_ovf));
      chk("inveto",    int'(inveto),    int'(!passthrough && (m_since < int'(cycles_to_veto))));
      chk("rd_valid",  int'(rd_valid),  int'(m_rdv));
      if (m_rdv) chk("rd_data", int'(rd_data), m_rdd);
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clkin);
      #1;
    end
  endtask

  task automatic rd_chk(input string name, input bit sel, input int addr, input int exp);
    rd_en = 1'b1; rd_sel = sel; rd_addr = AW'(addr);
    tick();
    rd_en = 1'b0;
    chk(name, int'(rd_data), exp);
    chk({name, "_valid"}, int'(rd_valid), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int             n, len, cnt;
    logic [7:0]     pat;
    rst = 1'b1; lvds_rx = '0; mask1 = '0; mask2 = '0; passthrough = 1'b0;
    edge_mode = 1'b0; cycles_to_veto = '0; clear_req = 1'b0;
    rd_en = 1'b0; rd_sel = 1'b0; rd_addr = '0;
    tick(2);
    // reset state
    chk("rst_out1", int'(out1), 0);
    chk("rst_out2", int'(out2), 0);
    chk("rst_collision", int'(collision), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_inveto", int'(inveto), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick(2);

    // edge mode: held level yields one photon
    edge_mode = 1'b1; mask1 = 8'h01; lvds_rx = 8'h01;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin tick(); cnt += int'(out1); end
    lvds_rx = '0;
    tick(); cnt += int'(out1);
    chk("edge_out1_pulses", cnt, 1);
    rd_chk("edge_chan0", 1'b0, 0, 1);
    rd_chk("edge_chan1", 1'b0, 1, 0);

    // IPI binning: interval 5 on ch2 -> bin 4
    edge_mode = 1'b0; mask2 = 8'h04;
    tick(20);
    lvds_rx = 8'h04; tick(); lvds_rx = '0; tick(4);
    lvds_rx = 8'h04; tick(); lvds_rx = '0; tick();
    for (int k = 0; k < NIPI; k++)
      rd_chk($sformatf("ipi_bin%0d", k), 1'b1, k, (k == 4) ? 1 : 0);
    rd_chk("ipi_chan2", 1'b0, 2, 2);

    // veto: photons on ch1 at t, t+2, t+6 with dead time 3
    cycles_to_veto = 8'd3;
    tick(20);
    pat = 8'b0100_0101;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      lvds_rx = pat[c] ? 8'h02 : 8'h00;
      tick();
      cnt += int'(collision);
      if (c == 0) chk("veto_inveto_after_accept", int'(inveto), 1);
    end
    lvds_rx = '0; tick();
    cnt += int'(collision);
    chk("veto_collision_pulses", cnt, 1);
    rd_chk("veto_ipi5", 1'b1, 5, 1);
    rd_chk("veto_ipi4", 1'b1, 4, 1);
    rd_chk("veto_chan1", 1'b0, 1, 2);
    cycles_to_veto = '0;

    // saturation: 20 back-to-back photons on ch0
    tick(20);
    lvds_rx = 8'h01; tick(20); lvds_rx = '0;
    tick(3);
    chk("sat_overflow_sticky", int'(overflow), 1);
    rd_chk("sat_chan0", 1'b0, 0, 15);
    rd_chk("sat_ipi0", 1'b1, 0, 15);

    // clear sequence with a photon injected mid-clear
    clear_req = 1'b1;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    chk("clr_busy_delay", n, 3);
    len = 0;
    while (busy && len < 100) begin
      lvds_rx = (len == 5) ? 8'h01 : 8'h00;
      tick(); len++;
    end
    lvds_rx = '0;
    chk("clr_busy_len", len, NIPI);
    chk("clr_overflow", int'(overflow), 0);
    clear_req = 1'b0;
    tick(2);
    for (int i = 0; i < NCH; i++)  rd_chk($sformatf("clr_chan%0d", i), 1'b0, i, 0);
    for (int k = 0; k < NIPI; k++) rd_chk($sformatf("clr_ipi%0d", k), 1'b1, k, 0);

    // passthrough and out-of-range read
    passthrough = 1'b1; mask1 = '0; lvds_rx = 8'h80;
    tick();
    chk("pt_out1", int'(out1), 0);
    chk("pt_out2", int'(out2), 1);
    passthrough = 1'b0; lvds_rx = '0;
    tick();
    rd_chk("pt_chan7", 1'b0, 7, 0);
    rd_chk("oor_chan", 1'b0, NCH, 0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
